dht11_disp_fmt: RTL

DHT11_DISP_FMT -- requirements
Module: dht11_disp_fmt

---
 rtl/dht11_disp_fmt_pkg.sv | 47 ++++
 rtl/dht11_disp_fmt_bin2bcd8_seq.sv | 43 ++++
 rtl/dht11_disp_fmt.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dht11_disp_fmt_pkg.sv
// DHT11 display formatter: shared types and constants.
// FSM states, ASCII codes and the fixed 16-character line templates.
package dht11_disp_fmt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CONV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_DASH = 8'h2D;
  localparam logic [7:0] ASC_0    = 8'h30;

  localparam logic [47:0] L1_PRE = "HUMI: ";
  localparam logic [55:0] L1_SUF = " %RH   ";
  localparam logic [47:0] L2_PRE = "TEMP: ";
  localparam logic [55:0] L2_SUF = " C     ";
  localparam logic [47:0] L3_PRE = "ERR : ";
  localparam logic [55:0] L3_SUF = "       ";

  localparam logic [127:0] L4_OK   = "CRC OK          ";
  localparam logic [127:0] L4_ERR  = "CRC ERR         ";
  localparam logic [127:0] L4_WAIT = "WAITING...      ";

  localparam logic [23:0] DASH3 = {ASC_DASH, ASC_DASH, ASC_DASH};
  localparam logic [23:0] ZERO3 = {ASC_SP, ASC_SP, ASC_0};

  localparam logic [127:0] L1_RST = {L1_PRE, DASH3, L1_SUF};
  localparam logic [127:0] L2_RST = {L2_PRE, DASH3, L2_SUF};
  localparam logic [127:0] L3_RST = {L3_PRE, ZERO3, L3_SUF};

  // Three BCD digits to ASCII, leading zeros blanked, units always shown.
  function automatic logic [23:0] fmt3(input logic [11:0] b);
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] u;
    h = (b[11:8] == 4'd0) ? ASC_SP : (ASC_0 + {4'd0, b[11:8]});
    t = (b[11:8] == 4'd0 && b[7:4] == 4'd0) ?
        ASC_SP : (ASC_0 + {4'd0, b[7:4]});
    u = ASC_0 + {4'd0, b[3:0]};
    return {h, t, u};
  endfunction

endpackage

// File: rtl/dht11_disp_fmt_bin2bcd8_seq.sv
// Iterative 8-bit binary to 3-digit BCD (shift-add-3).
// START loads the operand; eight following cycles each do one step.
module bin2bcd8_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  BIN,
  output logic [11:0] BCD,
  output logic        DONE
);

  logic [7:0] sh;
  logic [3:0] cnt;

  function automatic logic [11:0] adj3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    if (r[3:0] >= 4'd5)  r[3:0]  = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5)  r[7:4]  = r[7:4] + 4'd3;
    if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
    return r;
  endfunction

  // Load on START, then one correct-and-shift step per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh  <= '0;
      BCD <= '0;
      cnt <= '0;
    end else if (START) begin
      sh  <= BIN;
      BCD <= '0;
      cnt <= 4'd8;
    end else if (cnt != 4'd0) begin
      {BCD, sh} <= {adj3(BCD), sh} << 1;
      cnt       <= cnt - 4'd1;
    end
  end

  // High during the final step: BCD is complete after this edge.
  assign DONE = (cnt == 4'd1);

endmodule

// File: rtl/dht11_disp_fmt.sv
// DHT11 frame to four 16-char text lines for a character display.
// Checksum, 8-cycle BCD conversion, then a single-cycle line update.
module dht11_disp_fmt
  import dht11_disp_fmt_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic [39:0]  FRAME_DAT,
  input  logic         FRAME_VLD,
  output logic [127:0] LINE1_DAT,
  output logic [127:0] LINE2_DAT,
  output logic [127:0] LINE3_DAT,
  output logic [127:0] LINE4_DAT,
  output logic         BUSY,
  output logic         UPD
);

  state_t      state;
  state_t      nxt;
  logic [39:0] frame;
  logic [7:0]  err_cnt;
  logic [7:0]  err_nxt;
  logic [7:0]  sum;
  logic        chk_pass;
  logic        crc_ok;
  logic        start;
  logic        conv_done;
  logic [11:0] bcd_h;
  logic [11:0] bcd_t;
  logic [11:0] bcd_e;
  logic        dn_h;
  logic        dn_t;
  logic        dn_e;

  assign sum = frame[39:32] + frame[31:24]
             + frame[23:16] + frame[15:8];
  assign chk_pass = (sum == frame[7:0]);
  assign err_nxt = (!chk_pass && err_cnt != 8'hFF) ?
                   err_cnt + 8'd1 : err_cnt;
  assign start = (state == S_CHECK);
  assign conv_done = dn_h & dn_t & dn_e;

  bin2bcd8_seq u_hum (
    .CLK   (CLK),
    .RST   (RST),
    .START (start),
    .BIN   (frame[39:32]),
    .BCD   (bcd_h),
    .DONE  (dn_h)
  );

  bin2bcd8_seq u_tmp (
    .CLK   (CLK),
    .RST   (RST),
    .START (start),
    .BIN   (frame[23:16]),
    .BCD   (bcd_t),
    .DONE  (dn_t)
  );

  // Error count converted is the value after this frame's check.
  bin2bcd8_seq u_err (
    .CLK   (CLK),
    .RST   (RST),
    .START (start),
    .BIN   (err_nxt),
    .BCD   (bcd_e),
    .DONE  (dn_e)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next state and status outputs.
  always_comb begin
    nxt  = state;
    BUSY = (state != S_IDLE);
    UPD  = 1'b0;
    unique case (state)
      S_IDLE:  if (FRAME_VLD) nxt = S_CHECK;
      S_CHECK: nxt = S_CONV;
      S_CONV:  if (conv_done) nxt = S_WRITE;
      S_WRITE: nxt = S_DONE;
      S_DONE: begin
        UPD = 1'b1;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Frame capture only when idle; later strobes are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) frame <= '0;
    else if (state == S_IDLE && FRAME_VLD) frame <= FRAME_DAT;
  end

  // Checksum verdict and saturating error count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
      crc_ok  <= 1'b0;
    end else if (state == S_CHECK) begin
      err_cnt <= err_nxt;
      crc_ok  <= chk_pass;
    end
  end

  // Display lines; measurements kept on a bad frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LINE1_DAT <= L1_RST;
      LINE2_DAT <= L2_RST;
      LINE3_DAT <= L3_RST;
      LINE4_DAT <= L4_WAIT;
    end else if (state == S_WRITE) begin
      if (crc_ok) begin
        LINE1_DAT <= {L1_PRE, fmt3(bcd_h), L1_SUF};
        LINE2_DAT <= {L2_PRE, fmt3(bcd_t), L2_SUF};
      end
      LINE3_DAT <= {L3_PRE, fmt3(bcd_e), L3_SUF};
      LINE4_DAT <= crc_ok ? L4_OK : L4_ERR;
    end
  end

endmodule
